zkbd_loader: RTL

ZKBD_LOADER -- requirements
Module: zkbd_loader

---
 rtl/zkbd_loader_pkg.sv | 14 +
 rtl/zkbd_loader_tmo.sv | 24 ++
 rtl/zkbd_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/zkbd_loader_pkg.sv
// Shared command codes and FSM types for the keyboard/mouse frame loader.
package zkbd_loader_pkg;

   localparam logic [7:0] CMD_KBD = 8'h10;
   localparam logic [7:0] CMD_MX  = 8'h11;
   localparam logic [7:0] CMD_MY  = 8'h12;
   localparam logic [7:0] CMD_BTN = 8'h13;
   localparam logic [7:0] CMD_KJ  = 8'h14;

   typedef enum logic [2:0] {IDLE, CMD, KBD, ONE, SKIP} state_e;

   typedef enum logic [1:0] {TGT_X, TGT_Y, TGT_BTN, TGT_KJ} tgt_e;

endpackage

// File: rtl/zkbd_loader_tmo.sv
// Inter-byte timeout counter: saturates at all-ones and flags expiry.
module zkbd_loader_tmo #(
   parameter int unsigned TMO_W = 16
) (
   input  logic i_fclk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   logic [TMO_W-1:0] r_cnt;

   always_ff @(posedge i_fclk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = &r_cnt;

endmodule

// File: rtl/zkbd_loader.sv
// Collects SPI command frames from the AVR into keyboard-matrix and mouse/joystick outputs.
// Define ZKBD_LOADER_KJOY_EN to enable joystick command 0x14 and the kj_stb output.
module zkbd_loader
   import zkbd_loader_pkg::*;
#(
   parameter int unsigned KBD_BYTES = 5,
   parameter int unsigned TMO_W     = 16
) (
   input  logic                   fclk,
   input  logic                   rst,
   input  logic                   scs_start,
   input  logic                   scs_end,
   input  logic [7:0]             byte_in,
   input  logic                   byte_stb,
   output logic [8*KBD_BYTES-1:0] kbd_out,
   output logic                   kbd_stb,
   output logic [7:0]             mus_out,
   output logic                   mus_xstb,
   output logic                   mus_ystb,
   output logic                   mus_btnstb,
   output logic                   kj_stb,
   output logic                   busy
);

   localparam int unsigned KW = 8 * KBD_BYTES;
   localparam int unsigned CW = $clog2(KBD_BYTES + 1);

   state_e          r_state, w_state_nxt, w_cur;
   tgt_e            r_tgt, w_tgt_nxt;
   logic [CW-1:0]   r_bcnt, w_bcnt_nxt;
   logic [KW-1:0]   r_shift, w_shift_nxt;
   logic [KW-1:0]   r_kbd;
   logic [7:0]      r_mus;
   logic            r_kbd_stb, r_xstb, r_ystb, r_btnstb;
   logic            w_kbd_fire, w_mus_load;
   logic            w_tmo_exp, w_tmo_clr;

   zkbd_loader_tmo #(
      .TMO_W(TMO_W)
   ) u_tmo (
      .i_fclk    (fclk),
      .i_rst     (rst),
      .i_clr     (w_tmo_clr),
      .i_en      (busy),
      .o_expired (w_tmo_exp)
   );

   assign w_tmo_clr = byte_stb | scs_start | ~busy;

   always_ff @(posedge fclk) begin
      if (rst) begin
         r_state <= IDLE;
         r_tgt   <= TGT_X;
         r_bcnt  <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tgt   <= w_tgt_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   // A byte arriving with scs_start is decoded as the new transfer's command.
   always_comb begin
      w_cur       = scs_start ? CMD : r_state;
      w_state_nxt = w_cur;
      w_tgt_nxt   = r_tgt;
      w_bcnt_nxt  = scs_start ? '0 : r_bcnt;
      w_shift_nxt = scs_start ? '0 : r_shift;
      w_kbd_fire  = 1'b0;
      w_mus_load  = 1'b0;
      if (byte_stb) begin
         case (w_cur)
            CMD: begin
               w_bcnt_nxt = '0;
               case (byte_in)
                  CMD_KBD: w_state_nxt = KBD;
                  CMD_MX: begin
                     w_state_nxt = ONE;
                     w_tgt_nxt   = TGT_X;
                  end
                  CMD_MY: begin
                     w_state_nxt = ONE;
                     w_tgt_nxt   = TGT_Y;
                  end
                  CMD_BTN: begin
                     w_state_nxt = ONE;
                     w_tgt_nxt   = TGT_BTN;
                  end
`ifdef ZKBD_LOADER_KJOY_EN
                  CMD_KJ: begin
                     w_state_nxt = ONE;
                     w_tgt_nxt   = TGT_KJ;
                  end
`endif
                  default: w_state_nxt = SKIP;
               endcase
            end
            KBD: begin
               w_shift_nxt = KW'({r_shift, byte_in});
               if (r_bcnt == CW'(KBD_BYTES - 1)) begin
                  w_kbd_fire  = 1'b1;
                  w_bcnt_nxt  = '0;
                  w_state_nxt = SKIP;
               end else begin
                  w_bcnt_nxt = r_bcnt + 1'b1;
               end
            end
            ONE: begin
               w_mus_load  = 1'b1;
               w_state_nxt = SKIP;
            end
            default: ;
         endcase
      end else if (!scs_start && w_tmo_exp &&
                   (w_cur == CMD || w_cur == KBD || w_cur == ONE)) begin
         w_state_nxt = IDLE;
      end
      if (scs_end && !scs_start) begin
         w_state_nxt = IDLE;
      end
   end

   always_comb begin
      busy = (r_state == CMD) || (r_state == KBD) || (r_state == ONE);
   end

   always_ff @(posedge fclk) begin
      if (rst) begin
         r_kbd     <= '0;
         r_mus     <= '0;
         r_kbd_stb <= 1'b0;
         r_xstb    <= 1'b0;
         r_ystb    <= 1'b0;
         r_btnstb  <= 1'b0;
      end else begin
         r_kbd_stb <= w_kbd_fire;
         r_xstb    <= w_mus_load && (r_tgt == TGT_X);
         r_ystb    <= w_mus_load && (r_tgt == TGT_Y);
         r_btnstb  <= w_mus_load && (r_tgt == TGT_BTN);
         if (w_kbd_fire) begin
            r_kbd <= w_shift_nxt;
         end
         if (w_mus_load) begin
            r_mus <= byte_in;
         end
      end
   end

`ifdef ZKBD_LOADER_KJOY_EN
   logic r_kj_stb;

   always_ff @(posedge fclk) begin
      if (rst) begin
         r_kj_stb <= 1'b0;
      end else begin
         r_kj_stb <= w_mus_load && (r_tgt == TGT_KJ);
      end
   end

   assign kj_stb = r_kj_stb;
`else
   assign kj_stb = 1'b0;
`endif

   assign kbd_out    = r_kbd;
   assign kbd_stb    = r_kbd_stb;
   assign mus_out    = r_mus;
   assign mus_xstb   = r_xstb;
   assign mus_ystb   = r_ystb;
   assign mus_btnstb = r_btnstb;

endmodule
